cpu_sram_slave: RTL and testbench
=================================

# cpu_sram_slave

Synchronous single-port SRAM responder for the CPU's inst/data SRAM interface (`we`, `addr`, `wdata`, `rdata`). Each instance serves one CPU port: it decodes the byte address into a word index inside a configured window, performs writes, and returns read data one cycle later. It also keeps access counters and a sticky out-of-range flag for the bench and debug. The multi-cycle core uses one instance for instruction fetch and one for data.

## Interface
Parameters:
- `ADDR_W`, 14: word-index width; window size is 2^ADDR_W words.
- `BASE_ADDR`, 32'h1c00_0000: byte address of word 0; must be 4-byte aligned.

Ports:
- `clk`  in  1  single clock; everything updates on the rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `sram_en`  in  1  access enable; CPU ties high or drives from `valid`.
- `sram_we`  in  1  write enable; qualified by `sram_en`.
- `sram_addr`  in  32  byte address.
- `sram_wdata`  in  32  write data.
- `sram_rdata`  out  32  read data, registered.
- `rd_cnt`  out  32  count of accepted reads.
- `wr_cnt`  out  32  count of accepted writes.
- `err_oor`  out  1  sticky flag: an access was out of range or misaligned.

## Operation
- Offset: `off = sram_addr - BASE_ADDR`, 32-bit modulo subtraction. Word index: `idx = off[ADDR_W+1:2]`.
- In range when `off < 4*2^ADDR_W` (unsigned) and `sram_addr[1:0] == 2'b00`.
- Accepted access: `sram_en=1` and in range. Write if `sram_we=1`, otherwise read.
- Write: `mem[idx] <= sram_wdata`. `sram_rdata` also updates on a write cycle. It returns the old `mem[idx]`, or the forwarded data when the bypass is compiled in (see Configuration).
- Read: `sram_rdata <= mem[idx]`.
- `sram_en=0`: no array access; `sram_rdata` holds its value; counters unchanged.
- Bad access (`sram_en=1` and not in range):
  - write discarded;
  - `sram_rdata <= 32'h0`;
  - `err_oor <= 1`;
  - counters unchanged.
- `err_oor` is cleared only by `reset`.
- Counters: increment by 1 per accepted read or write; saturate at 32'hFFFF_FFFF.
- Memory contents are not reset. They are undefined until written, or until preloaded by the bench through hierarchical `$readmemh`.

## Timing
- Read latency is 1 cycle: address in cycle N, data valid in `sram_rdata` after edge N+1 and held until the next enabled access.
- Write commits at the edge ending cycle N. A read of the same word in cycle N+1 returns the new data.
- Back-to-back accesses are allowed every cycle. There is no stall and no handshake; the responder is always ready.
- Reset values: `sram_rdata=0`, `rd_cnt=0`, `wr_cnt=0`, `err_oor=0`.
- A write presented in a cycle where `reset=1` is suppressed; the array is unchanged.
- Reset asserted mid-sequence: the cycle after reset deasserts, the outputs show their reset values. The first access after that behaves normally with 1-cycle latency.
- Wrap-around:
  - an `sram_addr` below `BASE_ADDR` wraps to a large `off` and is out of range;
  - the last in-range word is `BASE_ADDR + 4*(2^ADDR_W) - 4`.
- A counter at saturation stays at all-ones. Simultaneous saturation of both counters is impossible (one access per cycle).

## Configuration
- `CPU_SRAM_WR_BYPASS_EN` defined: on an accepted write, `sram_rdata <= sram_wdata` (write-first behaviour).
- Not defined: on an accepted write, `sram_rdata <= mem[idx]` old value (read-first behaviour).
- The macro does not change any other behaviour.

## Test plan
- Reset: hold `reset=1` 3 cycles while driving `sram_en=1`, `sram_we=1`, `sram_addr=BASE_ADDR`, `sram_wdata=32'h1234_5678` -> all outputs 0. A following read of `BASE_ADDR` does not return 32'h1234_5678.
- Write/read: write 32'hCAFE_F00D to 32'h1c00_0010, then read it -> `sram_rdata=32'hCAFE_F00D` one cycle after the read address; `wr_cnt=1`, `rd_cnt=1`.
- Write cycle output: `mem[0]=32'h1111_1111`, then write 32'h2222_2222 to `BASE_ADDR` -> `sram_rdata` after that edge is 32'h2222_2222 with the bypass defined, 32'h1111_1111 without it.
- Bad accesses (`ADDR_W=14`):
  - write to 32'h1c01_0000 (one past the end) -> discarded, `sram_rdata=0`, `err_oor=1`, `wr_cnt` unchanged;
  - read of 32'h1bff_fffc (below base) -> `sram_rdata=0`, `err_oor` stays 1;
  - read of 32'h1c00_0002 (misaligned) -> `sram_rdata=0`, `err_oor` stays 1.
- Back-to-back reads of 32'h1c00_0000, ..._0004, ..._0008 on consecutive cycles, preloaded with 1, 2, 3 -> `sram_rdata` reads 1, 2, 3 on consecutive cycles. With `sram_en=0` on the 4th cycle, `sram_rdata` holds 3.
- Counter saturation: force `rd_cnt` to 32'hFFFF_FFFE, then issue 3 reads -> `rd_cnt` reads 32'hFFFF_FFFF and stays there.

Source files
------------

// File: rtl/cpu_sram_slave.sv
// Single-port SRAM responder for one CPU inst/data port: windowed word decode, 1-cycle
// registered read, saturating access counters, sticky range error. Macro: CPU_SRAM_WR_BYPASS_EN.
module cpu_sram_slave #(
   parameter int unsigned ADDR_W    = 14,
   parameter logic [31:0] BASE_ADDR = 32'h1c00_0000
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        sram_en,
   input  logic        sram_we,
   input  logic [31:0] sram_addr,
   input  logic [31:0] sram_wdata,
   output logic [31:0] sram_rdata,
   output logic [31:0] rd_cnt,
   output logic [31:0] wr_cnt,
   output logic        err_oor
);

   localparam int unsigned Depth = 2 ** ADDR_W;

   logic [31:0]       mem [Depth];

   logic [31:0]       off;
   logic [ADDR_W-1:0] idx;
   logic              in_range;
   logic              acc_rd;
   logic              acc_wr;
   logic              bad_acc;
   logic [31:0]       mem_rd;

   logic [31:0]       rdata_d, rdata_q;
   logic [31:0]       rd_cnt_d, rd_cnt_q;
   logic [31:0]       wr_cnt_d, wr_cnt_q;
   logic              err_d, err_q;

   // Addresses below the base wrap to a huge offset and fail the upper-bits test.
   // BASE_ADDR is word aligned, so the offset's low bits equal the address's low bits.
   always_comb begin
      off      = sram_addr - BASE_ADDR;
      idx      = off[ADDR_W+1:2];
      in_range = (off[31:ADDR_W+2] == '0) && (off[1:0] == 2'b00);
      acc_wr   = sram_en && in_range && sram_we && !reset;
      acc_rd   = sram_en && in_range && !sram_we;
      bad_acc  = sram_en && !in_range;
      mem_rd   = mem[idx];
   end

   always_comb begin
      rdata_d  = rdata_q;
      rd_cnt_d = rd_cnt_q;
      wr_cnt_d = wr_cnt_q;
      err_d    = err_q;

      if (acc_rd) begin
         rdata_d = mem_rd;
         if (rd_cnt_q != 32'hFFFF_FFFF) begin
            rd_cnt_d = rd_cnt_q + 32'd1;
         end
      end else if (acc_wr) begin
`ifdef CPU_SRAM_WR_BYPASS_EN
         rdata_d = sram_wdata;
`else
         rdata_d = mem_rd;
`endif
         if (wr_cnt_q != 32'hFFFF_FFFF) begin
            wr_cnt_d = wr_cnt_q + 32'd1;
         end
      end else if (bad_acc) begin
         rdata_d = 32'h0;
         err_d   = 1'b1;
      end
   end

   // Array is deliberately not reset; acc_wr already excludes reset cycles.
   always_ff @(posedge clk) begin
      if (acc_wr) begin
         mem[idx] <= sram_wdata;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         rdata_q  <= 32'h0;
         rd_cnt_q <= 32'h0;
         wr_cnt_q <= 32'h0;
         err_q    <= 1'b0;
      end else begin
         rdata_q  <= rdata_d;
         rd_cnt_q <= rd_cnt_d;
         wr_cnt_q <= wr_cnt_d;
         err_q    <= err_d;
      end
   end

   assign sram_rdata = rdata_q;
   assign rd_cnt     = rd_cnt_q;
   assign wr_cnt     = wr_cnt_q;
   assign err_oor    = err_q;

endmodule

// File: tb/tb_cpu_sram_slave.sv
// Randomized self-checking bench for cpu_sram_slave against an associative-array memory model.
module tb_cpu_sram_slave;

   localparam int unsigned ADDR_W    = 14;
   localparam logic [31:0] BASE_ADDR = 32'h1c00_0000;
   localparam logic [31:0] WIN_BYTES = 32'd4 << ADDR_W;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        sram_en = 1'b0;
   logic        sram_we = 1'b0;
   logic [31:0] sram_addr = '0;
   logic [31:0] sram_wdata = '0;
   logic [31:0] sram_rdata;
   logic [31:0] rd_cnt;
   logic [31:0] wr_cnt;
   logic        err_oor;

   int n_tests = 0;
   int n_fail  = 0;

   // Reference state
   logic [31:0] model_mem [logic [31:0]];
   logic [31:0] exp_rdata;
   bit          exp_rdata_known;
   logic [31:0] exp_rd;
   logic [31:0] exp_wr;
   logic        exp_err;

   cpu_sram_slave #(
      .ADDR_W   (ADDR_W),
      .BASE_ADDR(BASE_ADDR)
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .sram_en   (sram_en),
      .sram_we   (sram_we),
      .sram_addr (sram_addr),
      .sram_wdata(sram_wdata),
      .sram_rdata(sram_rdata),
      .rd_cnt    (rd_cnt),
      .wr_cnt    (wr_cnt),
      .err_oor   (err_oor)
   );

   always #5 clk = ~clk;

   function automatic bit addr_ok(input logic [31:0] a);
      return (a >= BASE_ADDR) && (a < BASE_ADDR + WIN_BYTES) && (a % 4 == 0);
   endfunction

   // Drives one cycle, updates the model from the access rules, returns at posedge+1.
   task automatic cycle(input bit en, input bit we, input logic [31:0] a, input logic [31:0] d);
      bit          old_known;
      logic [31:0] old;
      sram_en    = en;
      sram_we    = we;
      sram_addr  = a;
      sram_wdata = d;
      old_known  = model_mem.exists(a);
      old        = old_known ? model_mem[a] : 32'h0;
      @(posedge clk);
      #1;
      if (reset) begin
         exp_rdata = 0; exp_rdata_known = 1; exp_rd = 0; exp_wr = 0; exp_err = 0;
      end else if (en && addr_ok(a)) begin
         if (we) begin
`ifdef CPU_SRAM_WR_BYPASS_EN
            exp_rdata = d; exp_rdata_known = 1;
`else
            exp_rdata = old; exp_rdata_known = old_known;
`endif
            model_mem[a] = d;
            if (exp_wr != 32'hFFFF_FFFF) exp_wr++;
         end else begin
            exp_rdata = old; exp_rdata_known = old_known;
            if (exp_rd != 32'hFFFF_FFFF) exp_rd++;
         end
      end else if (en) begin
         exp_rdata = 0; exp_rdata_known = 1; exp_err = 1;
      end
   endtask

   task automatic do_reset();
      reset = 1'b1;
      cycle(0, 0, 0, 0);
      reset = 1'b0;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      for (int i = 0; i < 3; i++) cycle(1, 1, BASE_ADDR, 32'h1234_5678);
      reset = 1'b0;
      n_tests++;
      if (sram_rdata !== 0 || rd_cnt !== 0 || wr_cnt !== 0 || err_oor !== 0) begin
         n_fail++;
         $display("FAIL reset_outputs: rdata=%h rd=%h wr=%h err=%b, want all 0",
                  sram_rdata, rd_cnt, wr_cnt, err_oor);
      end
      cycle(1, 0, BASE_ADDR, 0);
      n_tests++;
      if (sram_rdata === 32'h1234_5678) begin
         n_fail++;
         $display("FAIL reset_write_suppressed: rdata=%h, want anything but 12345678", sram_rdata);
      end
   endtask

   task automatic test_write_read();
      do_reset();
      cycle(1, 1, 32'h1c00_0010, 32'hCAFE_F00D);
      cycle(1, 0, 32'h1c00_0010, 0);
      n_tests++;
      if (sram_rdata !== 32'hCAFE_F00D || wr_cnt !== 1 || rd_cnt !== 1 || err_oor !== 0) begin
         n_fail++;
         $display("FAIL write_read: rdata=%h wr=%0d rd=%0d err=%b, want cafef00d 1 1 0",
                  sram_rdata, wr_cnt, rd_cnt, err_oor);
      end
   endtask

   task automatic test_write_cycle_output();
      logic [31:0] want;
`ifdef CPU_SRAM_WR_BYPASS_EN
      want = 32'h2222_2222;
`else
      want = 32'h1111_1111;
`endif
      do_reset();
      cycle(1, 1, BASE_ADDR, 32'h1111_1111);
      cycle(1, 1, BASE_ADDR, 32'h2222_2222);
      n_tests++;
      if (sram_rdata !== want) begin
         n_fail++;
         $display("FAIL write_cycle_rdata: got %h, want %h", sram_rdata, want);
      end
      cycle(1, 0, BASE_ADDR, 0);
      n_tests++;
      if (sram_rdata !== 32'h2222_2222) begin
         n_fail++;
         $display("FAIL write_then_read: got %h, want 22222222", sram_rdata);
      end
   endtask

   task automatic test_bad_access();
      logic [31:0] bad_addr [3];
      bad_addr[0] = 32'h1c01_0000;
      bad_addr[1] = 32'h1bff_fffc;
      bad_addr[2] = 32'h1c00_0002;
      do_reset();
      cycle(1, 1, 32'h1c00_fffc, 32'hA5A5_0001);
      cycle(1, 0, 32'h1c00_fffc, 0);
      n_tests++;
      if (sram_rdata !== 32'hA5A5_0001 || err_oor !== 0) begin
         n_fail++;
         $display("FAIL last_word: rdata=%h err=%b, want a5a50001 0", sram_rdata, err_oor);
      end
      for (int i = 0; i < 3; i++) begin
         cycle(1, (i == 0), bad_addr[i], 32'hDEAD_BEEF);
         n_tests++;
         if (sram_rdata !== 0 || err_oor !== 1 || wr_cnt !== 1 || rd_cnt !== 1) begin
            n_fail++;
            $display("FAIL bad_access_%0d: rdata=%h err=%b wr=%0d rd=%0d, want 0 1 1 1",
                     i, sram_rdata, err_oor, wr_cnt, rd_cnt);
         end
      end
      // The discarded write must not alias onto word 0.
      cycle(1, 1, BASE_ADDR, 32'h0000_0055);
      cycle(1, 0, BASE_ADDR, 0);
      n_tests++;
      if (sram_rdata !== 32'h0000_0055 || err_oor !== 1) begin
         n_fail++;
         $display("FAIL err_sticky: rdata=%h err=%b, want 00000055 1", sram_rdata, err_oor);
      end
   endtask

   task automatic test_back_to_back();
      do_reset();
      for (int i = 0; i < 3; i++) cycle(1, 1, BASE_ADDR + 4 * i, i + 1);
      for (int i = 0; i < 3; i++) begin
         cycle(1, 0, BASE_ADDR + 4 * i, 0);
         n_tests++;
         if (sram_rdata !== i + 1) begin
            n_fail++;
            $display("FAIL b2b_read_%0d: got %h, want %h", i, sram_rdata, i + 1);
         end
      end
      cycle(0, 0, BASE_ADDR, 0);
      n_tests++;
      if (sram_rdata !== 3 || rd_cnt !== 3) begin
         n_fail++;
         $display("FAIL en_low_hold: rdata=%h rd=%0d, want 3 3", sram_rdata, rd_cnt);
      end
   endtask

   task automatic test_saturation();
      do_reset();
      dut.rd_cnt_q = 32'hFFFF_FFFE;
      exp_rd = 32'hFFFF_FFFE;
      for (int i = 0; i < 3; i++) begin
         cycle(1, 0, BASE_ADDR, 0);
         n_tests++;
         if (rd_cnt !== 32'hFFFF_FFFF || wr_cnt !== 0) begin
            n_fail++;
            $display("FAIL rd_saturate_%0d: rd=%h wr=%h, want ffffffff 0", i, rd_cnt, wr_cnt);
         end
      end
   endtask

   task automatic test_random();
      logic [31:0] a;
      do_reset();
      for (int n = 0; n < 400; n++) begin
         case ($urandom_range(0, 5))
            0, 1, 2: a = BASE_ADDR + 4 * $urandom_range(0, 15);
            3:       a = BASE_ADDR + WIN_BYTES - 4 * $urandom_range(1, 8);
            4:       a = BASE_ADDR + WIN_BYTES + 4 * $urandom_range(0, 7);
            default: a = BASE_ADDR + $urandom_range(1, 63) - 32;
         endcase
         cycle(($urandom_range(0, 3) != 0), $urandom_range(0, 1), a, $urandom);
         n_tests++;
         if ((exp_rdata_known && sram_rdata !== exp_rdata) || rd_cnt !== exp_rd ||
             wr_cnt !== exp_wr || err_oor !== exp_err) begin
            n_fail++;
            $display("FAIL random_%0d addr=%h: rdata=%h rd=%0d wr=%0d err=%b, want %h %0d %0d %b",
                     n, a, sram_rdata, rd_cnt, wr_cnt, err_oor,
                     exp_rdata, exp_rd, exp_wr, exp_err);
         end
      end
   endtask

   initial begin
      exp_rdata = 0; exp_rdata_known = 0; exp_rd = 0; exp_wr = 0; exp_err = 0;
      @(negedge clk);
      test_reset();
      test_write_read();
      test_write_cycle_output();
      test_bad_access();
      test_back_to_back();
      test_saturation();
      test_random();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
